// File: rtl/mu_vel_cache_ctrl.sv
// -----------------------------------------------------------------------------
// mu_vel_cache_ctrl
//
// Motion-update sequencer for the double-buffered velocity cache. An accepted
// start opens a motion-update window: a one-cycle o_MU_start pulse, then
// o_MU_working held high. While the window is open, the block walks particle
// IDs 1..N as cache reads. Reads are metered against downstream ready and a
// credit limit on reads that have been issued but not yet written back.
// Write-backs from the motion-update pipeline return credits.
//
// The window closes only when every particle has been written back. After
// that, o_busy stays high for SWAP_HOLD cycles while the cache swaps phase.
//
// Cache read data arrives two cycles after o_MU_rd_en. Pairing that data with
// force data is the pipeline's job; this block only counts credits.
//
// Ports
//   clk               clock
//   rst               synchronous, active-high reset (aborts any run)
//   i_start           pulse: begin a motion update (ignored unless idle)
//   i_num_particles   particle count N, sampled on an accepted start
//   i_dn_ready        MU pipeline can accept one velocity this cycle
//   i_mu_wr_done      pulse: MU pipeline wrote one velocity back
//   o_MU_start        one-cycle pulse to the cache at window open
//   o_MU_working      level to the cache for the whole window
//   o_MU_rd_addr      cache read address (holds when o_MU_rd_en is low)
//   o_MU_rd_en        cache read enable
//   o_busy            high from accepted start to end of swap hold
//   o_done            one-cycle pulse when the window closes
//   o_err             sticky: write-back with nothing in flight, or count
//                     overflow
// -----------------------------------------------------------------------------
module mu_vel_cache_ctrl #(
  parameter int PARTICLE_ID_WIDTH = 8,
  parameter int MAX_INFLIGHT      = 4,
  parameter int SWAP_HOLD         = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_start,
  input  logic [PARTICLE_ID_WIDTH-1:0] i_num_particles,
  input  logic                         i_dn_ready,
  input  logic                         i_mu_wr_done,
  output logic                         o_MU_start,
  output logic                         o_MU_working,
  output logic [PARTICLE_ID_WIDTH-1:0] o_MU_rd_addr,
  output logic                         o_MU_rd_en,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_err
);

  localparam int W  = PARTICLE_ID_WIDTH;
  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam int HW = (SWAP_HOLD > 1) ? $clog2(SWAP_HOLD) : 1;

  localparam logic [IW-1:0] MAX_IF     = IW'(MAX_INFLIGHT);
  localparam logic [HW-1:0] HOLD_START = HW'((SWAP_HOLD > 0) ? SWAP_HOLD - 1 : 0);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_OPEN  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  logic [2:0]    state;
  logic [W-1:0]  n_lat;      // particle count for this window
  logic [W-1:0]  next_id;    // next particle ID to read
  logic [IW-1:0] inflight;   // reads issued but not yet written back
  logic [W:0]    wr_count;   // accepted write-backs in this window
  logic [HW-1:0] hold_cnt;

  logic          can_issue;
  logic          wr_bad;
  logic          wr_ok;
  logic [IW-1:0] inflight_nxt;
  logic [W:0]    wr_count_nxt;
  logic          drained;

  // The OPEN cycle already takes an issue decision. Its read therefore lands
  // in the first ISSUE cycle, right after the o_MU_start pulse. No read
  // enable is ever raised while o_MU_start is high.
  assign can_issue = ((state == S_OPEN) || (state == S_ISSUE)) &&
                     i_dn_ready && (inflight < MAX_IF);

  // A write-back with nothing outstanding, or one past N, is an error. It
  // must not disturb the credit or completion counters.
  assign wr_bad = i_mu_wr_done &&
                  ((inflight == '0) || (wr_count == {1'b0, n_lat}));
  assign wr_ok  = i_mu_wr_done && !wr_bad;

  // NOTE: every always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    inflight_nxt = inflight;
    if (can_issue && !wr_ok) begin
      inflight_nxt = inflight + IW'(1);
    end else if (!can_issue && wr_ok) begin
      inflight_nxt = inflight - IW'(1);
    end
  end

  assign wr_count_nxt = wr_count + {{W{1'b0}}, wr_ok};

  // The check looks at the post-update counts. The window therefore closes
  // on the edge that takes in the final write-back.
  assign drained = (inflight_nxt == '0) && (wr_count_nxt == {1'b0, n_lat});

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // reads the pre-edge value of every other register, regardless of
  // statement order.
  // NOTE: all control state sits in this one reset branch. A reset mid-run
  // leaves no stale credits or counts behind for the next window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      n_lat        <= '0;
      next_id      <= '0;
      inflight     <= '0;
      wr_count     <= '0;
      hold_cnt     <= '0;
      o_MU_start   <= 1'b0;
      o_MU_working <= 1'b0;
      o_MU_rd_addr <= '0;
      o_MU_rd_en   <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_MU_start <= 1'b0;
      o_MU_rd_en <= 1'b0;
      o_done     <= 1'b0;
      inflight   <= inflight_nxt;
      wr_count   <= wr_count_nxt;

      if (wr_bad) begin
        o_err <= 1'b1;
      end

      if (can_issue) begin
        o_MU_rd_en   <= 1'b1;
        o_MU_rd_addr <= next_id;
        next_id      <= next_id + W'(1);
      end

      case (state)
        S_IDLE: begin
          o_busy <= 1'b0;
          if (i_start) begin
            if (i_num_particles == '0) begin
              // Empty run: report completion at once, with no cache traffic.
              o_done <= 1'b1;
              o_busy <= 1'b1;
            end else begin
              n_lat        <= i_num_particles;
              next_id      <= W'(1);
              wr_count     <= '0;
              o_MU_start   <= 1'b1;
              o_MU_working <= 1'b1;
              o_busy       <= 1'b1;
              state        <= S_OPEN;
            end
          end
        end

        S_OPEN, S_ISSUE: begin
          if (can_issue && (next_id == n_lat)) begin
            state <= S_DRAIN;
          end else begin
            state <= S_ISSUE;
          end
        end

        S_DRAIN: begin
          if (drained) begin
            o_MU_working <= 1'b0;
            o_done       <= 1'b1;
            hold_cnt     <= HOLD_START;
            if (SWAP_HOLD == 0) begin
              o_busy <= 1'b0;
              state  <= S_IDLE;
            end else begin
              state <= S_HOLD;
            end
          end
        end

        S_HOLD: begin
          // The cache swaps buffer phase while this hold counts down.
          if (hold_cnt == '0) begin
            o_busy <= 1'b0;
            state  <= S_IDLE;
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mu_vel_cache_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mu_vel_cache_ctrl
//
// Testbench for mu_vel_cache_ctrl with the default parameters (W=8,
// MAX_INFLIGHT=4, SWAP_HOLD=2).
//
// Each vector holds the inputs applied for one cycle. Next to them are the
// registered outputs expected just after the clock edge that samples those
// inputs.
// -----------------------------------------------------------------------------
module tb_mu_vel_cache_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_start;
  logic [7:0] i_num_particles;
  logic       i_dn_ready;
  logic       i_mu_wr_done;
  logic       o_MU_start;
  logic       o_MU_working;
  logic [7:0] o_MU_rd_addr;
  logic       o_MU_rd_en;
  logic       o_busy;
  logic       o_done;
  logic       o_err;

  int checks = 0;
  int errors = 0;

  mu_vel_cache_ctrl #(
    .PARTICLE_ID_WIDTH(8),
    .MAX_INFLIGHT     (4),
    .SWAP_HOLD        (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_start        (i_start),
    .i_num_particles(i_num_particles),
    .i_dn_ready     (i_dn_ready),
    .i_mu_wr_done   (i_mu_wr_done),
    .o_MU_start     (o_MU_start),
    .o_MU_working   (o_MU_working),
    .o_MU_rd_addr   (o_MU_rd_addr),
    .o_MU_rd_en     (o_MU_rd_en),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_err          (o_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       start;
    logic [7:0] num;
    logic       ready;
    logic       wr;
    logic       ms;
    logic       w;
    logic       rd;
    logic [7:0] addr;
    logic       busy;
    logic       done;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic s, logic [7:0] n, logic rdy, logic wr,
                              logic ms, logic w, logic rd, logic [7:0] a,
                              logic b, logic d, logic e);
    vec_t v;
    v.rst = r;  v.start = s; v.num = n;  v.ready = rdy; v.wr = wr;
    v.ms = ms;  v.w = w;     v.rd = rd;  v.addr = a;
    v.busy = b; v.done = d;  v.err = e;
    return v;
  endfunction

  // Output bundle: {MU_start, MU_working, rd_en, busy, done, err, rd_addr}
  function automatic logic [13:0] outs();
    return {o_MU_start, o_MU_working, o_MU_rd_en, o_busy, o_done, o_err, o_MU_rd_addr};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic [7:0] n,
                      input logic rdy, input logic wr);
    rst = r; i_start = s; i_num_particles = n; i_dn_ready = rdy; i_mu_wr_done = wr;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (o_busy && k < 20) begin
      step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
      k++;
    end
    check(name, {31'd0, o_busy}, 32'd0);
  endtask

  initial begin
    logic [13:0] exp;
    int ms_pulses;

    rst = 1'b1; i_start = 1'b0; i_num_particles = '0; i_dn_ready = 1'b0; i_mu_wr_done = 1'b0;

    // Reset state
    vecs.push_back(mk(1,0,0,0,0, 0,0,0,0,0,0,0));
    // Case 1: N=3, ready high, each write-back 3 cycles after its read
    vecs.push_back(mk(0,1,3,1,0, 1,1,0,0,1,0,0));
    vecs.push_back(mk(0,0,0,1,0, 0,1,1,1,1,0,0));
    vecs.push_back(mk(0,0,0,1,0, 0,1,1,2,1,0,0));
    vecs.push_back(mk(0,0,0,1,0, 0,1,1,3,1,0,0));
    vecs.push_back(mk(0,0,0,1,0, 0,1,0,3,1,0,0));
    vecs.push_back(mk(0,0,0,1,1, 0,1,0,3,1,0,0));
    vecs.push_back(mk(0,0,0,1,1, 0,1,0,3,1,0,0));
    vecs.push_back(mk(0,0,0,1,1, 0,0,0,3,1,1,0));
    vecs.push_back(mk(0,0,0,1,0, 0,0,0,3,1,0,0));
    vecs.push_back(mk(0,0,0,1,0, 0,0,0,3,0,0,0));
    // Case 2: N=10, write-backs withheld -> credit stall after 4 reads
    vecs.push_back(mk(0,1,10,1,0, 1,1,0,3,1,0,0));
    vecs.push_back(mk(0,0,0,1,0,  0,1,1,1,1,0,0));
    vecs.push_back(mk(0,0,0,1,0,  0,1,1,2,1,0,0));
    vecs.push_back(mk(0,0,0,1,0,  0,1,1,3,1,0,0));
    vecs.push_back(mk(0,0,0,1,0,  0,1,1,4,1,0,0));
    vecs.push_back(mk(0,0,0,1,0,  0,1,0,4,1,0,0));
    vecs.push_back(mk(0,0,0,1,0,  0,1,0,4,1,0,0));
    vecs.push_back(mk(0,0,0,1,1,  0,1,0,4,1,0,0));
    vecs.push_back(mk(0,0,0,1,0,  0,1,1,5,1,0,0));
    vecs.push_back(mk(0,0,0,1,0,  0,1,0,5,1,0,0));
    vecs.push_back(mk(1,0,0,1,0,  0,0,0,0,0,0,0));
    // Case 3: N=5, ready toggling, interleaved write-backs
    vecs.push_back(mk(0,1,5,1,0, 1,1,0,0,1,0,0));
    vecs.push_back(mk(0,0,0,1,0, 0,1,1,1,1,0,0));
    vecs.push_back(mk(0,0,0,0,0, 0,1,0,1,1,0,0));
    vecs.push_back(mk(0,0,0,1,0, 0,1,1,2,1,0,0));
    vecs.push_back(mk(0,0,0,0,1, 0,1,0,2,1,0,0));
    vecs.push_back(mk(0,0,0,1,0, 0,1,1,3,1,0,0));
    vecs.push_back(mk(0,0,0,0,1, 0,1,0,3,1,0,0));
    vecs.push_back(mk(0,0,0,1,0, 0,1,1,4,1,0,0));
    vecs.push_back(mk(0,0,0,0,1, 0,1,0,4,1,0,0));
    vecs.push_back(mk(0,0,0,1,0, 0,1,1,5,1,0,0));
    vecs.push_back(mk(0,0,0,1,1, 0,1,0,5,1,0,0));
    vecs.push_back(mk(0,0,0,1,1, 0,0,0,5,1,1,0));
    vecs.push_back(mk(0,0,0,1,0, 0,0,0,5,1,0,0));
    vecs.push_back(mk(0,0,0,1,0, 0,0,0,5,0,0,0));

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].start, vecs[i].num, vecs[i].ready, vecs[i].wr);
      exp = {vecs[i].ms, vecs[i].w, vecs[i].rd, vecs[i].busy, vecs[i].done,
             vecs[i].err, vecs[i].addr};
      check($sformatf("vec%0d {ms,w,rd,busy,done,err,addr}", i), {18'd0, outs()}, {18'd0, exp});
    end

    // Case 4: a start during ISSUE is ignored; then an N=0 start from idle
    ms_pulses = 0;
    step(0, 1, 8'd2, 1, 0);
    check("c4 MU_start", {31'd0, o_MU_start}, 32'd1);
    step(0, 0, 8'd0, 1, 0);
    check("c4 first read", {23'd0, o_MU_rd_en, o_MU_rd_addr}, {23'd0, 1'b1, 8'd1});
    step(0, 1, 8'd7, 1, 0);
    check("c4 restart ignored", {22'd0, o_MU_start, o_MU_rd_en, o_MU_rd_addr},
          {22'd0, 1'b0, 1'b1, 8'd2});
    step(0, 0, 8'd0, 1, 1);
    ms_pulses += int'(o_MU_start);
    check("c4 no read past N", {22'd0, o_MU_rd_en, o_done, o_MU_rd_addr}, {22'd0, 2'b00, 8'd2});
    step(0, 0, 8'd0, 1, 1);
    ms_pulses += int'(o_MU_start);
    check("c4 done", {30'd0, o_done, o_MU_working}, {30'd0, 2'b10});
    wait_idle("c4 busy falls");
    check("c4 no second MU_start", ms_pulses, 32'd0);
    step(0, 1, 8'd0, 1, 0);
    check("c4 N=0 {ms,w,rd,busy,done}",
          {27'd0, o_MU_start, o_MU_working, o_MU_rd_en, o_busy, o_done},
          {27'd0, 5'b00011});
    step(0, 0, 8'd0, 1, 0);
    check("c4 N=0 after {busy,done}", {30'd0, o_busy, o_done}, 32'd0);

    // Case 5: spurious write-back in idle sets sticky error; reset clears it
    step(0, 0, 8'd0, 0, 1);
    check("c5 err set", {31'd0, o_err}, 32'd1);
    step(0, 0, 8'd0, 0, 0);
    step(0, 0, 8'd0, 0, 0);
    check("c5 err sticky", {31'd0, o_err}, 32'd1);
    step(1, 0, 8'd0, 0, 0);
    check("c5 err cleared", {31'd0, o_err}, 32'd0);

    // Case 6: reset mid-ISSUE with 2 reads in flight, then a fresh run
    step(0, 1, 8'd10, 1, 0);
    step(0, 0, 8'd0, 1, 0);
    step(0, 0, 8'd0, 1, 0);
    check("c6 two issued", {23'd0, o_MU_rd_en, o_MU_rd_addr}, {23'd0, 1'b1, 8'd2});
    step(1, 0, 8'd0, 0, 0);
    check("c6 reset outputs", {18'd0, outs()}, 32'd0);
    step(0, 0, 8'd0, 0, 0);
    check("c6 no late done", {30'd0, o_done, o_busy}, 32'd0);
    step(0, 1, 8'd1, 1, 0);
    check("c6 fresh MU_start", {31'd0, o_MU_start}, 32'd1);
    step(0, 0, 8'd0, 1, 0);
    check("c6 fresh addr", {23'd0, o_MU_rd_en, o_MU_rd_addr}, {23'd0, 1'b1, 8'd1});
    step(0, 0, 8'd0, 0, 1);
    check("c6 fresh done/err", {30'd0, o_done, o_err}, {30'd0, 2'b10});
    wait_idle("c6 busy falls");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
